// File: rtl/seq_ctrl_if.sv
// Handshake and control bundle between the run sequencer and its surroundings
// (TopLevel pins, fetch unit, data memory).
interface seq_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             Start;
  logic [8:0]       Instruction;
  logic             mem_ready;
  logic             pc_init;
  logic             pc_en;
  logic             mem_req;
  logic             Ack;
  logic             timeout_err;
  logic [CNT_W-1:0] cycle_count;

  // Environment side: drives the request, instruction word and memory ready.
  modport master (
    output Start, Instruction, mem_ready,
    input  pc_init, pc_en, mem_req, Ack, timeout_err, cycle_count
  );

  // Sequencer side.
  modport slave (
    input  Start, Instruction, mem_ready,
    output pc_init, pc_en, mem_req, Ack, timeout_err, cycle_count
  );
endinterface

// File: rtl/seq_ctrl.sv
// Run sequencer for the 9-bit core: Start/Ack handshake, PC init/advance,
// PC stall across multi-cycle loads/stores, cycle counter and memory timeout.
module seq_ctrl #(
  parameter int         CNT_W       = 16,
  parameter int         MEM_TIMEOUT = 15,      // 1..255
  parameter logic [8:0] HALT_INSTR  = 9'h1FF,
  parameter logic [2:0] OP_LW       = 3'b100,  // opcode field Instruction[8:6]
  parameter logic [2:0] OP_SW       = 3'b101
) (
  input  logic      Clk,
  input  logic      Reset_n,
  seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    RUN      = 3'd2,
    MEM_WAIT = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic             pc_init, pc_en, mem_req;
  logic             is_mem;

  assign is_mem = (bus.Instruction[8:6] == OP_LW) || (bus.Instruction[8:6] == OP_SW);

  // State, wait counter, cycle counter and sticky timeout flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state and combinational control outputs.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    pc_init = 1'b0;
    pc_en   = 1'b0;
    mem_req = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Start) state_d = INIT;
      end
      INIT: begin
        pc_init = 1'b1;
        wait_d  = '0;
        if (!bus.Start) state_d = RUN;
      end
      RUN: begin
        // Start aborts before anything else; HALT is checked before opcode decode.
        if (bus.Start) begin
          state_d = INIT;
        end else if (bus.Instruction == HALT_INSTR) begin
          state_d = DONE;
        end else if (is_mem) begin
          mem_req = 1'b1;
          if (bus.mem_ready) begin
            pc_en = 1'b1;
          end else begin
            state_d = MEM_WAIT;
            wait_d  = 8'd1;
          end
        end else begin
          pc_en = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.Start) begin
          state_d = INIT;
        end else if (bus.mem_ready) begin
          mem_req = 1'b1;
          pc_en   = 1'b1;
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == 8'(MEM_TIMEOUT)) begin
          state_d = DONE;
          terr_d  = 1'b1;
          wait_d  = '0;
        end else begin
          mem_req = 1'b1;
          wait_d  = wait_q + 8'd1;
        end
      end
      DONE: begin
        if (bus.Start) state_d = INIT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Count active cycles, saturating at all-ones.
    if (((state_q == RUN) || (state_q == MEM_WAIT)) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);

    // Entering or sitting in INIT starts a fresh run: counters and error clear,
    // so the first INIT cycle already shows the cleared values.
    if (state_d == INIT) begin
      cnt_d  = '0;
      terr_d = 1'b0;
      wait_d = '0;
    end
  end

  assign bus.pc_init     = pc_init;
  assign bus.pc_en       = pc_en;
  assign bus.mem_req     = mem_req;
  assign bus.Ack         = (state_q == DONE);
  assign bus.timeout_err = terr_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl with a 3-bit cycle counter and a 4-cycle memory
// timeout, so saturation and timeout are reachable in short runs.
module tb_seq_ctrl;
  localparam logic [8:0] HALT = 9'h1FF;
  localparam logic [8:0] LW   = 9'b100_010_001;
  localparam logic [8:0] SW   = 9'b101_001_010;
  localparam logic [8:0] A0   = 9'b000_001_010;
  localparam logic [8:0] A1   = 9'b001_010_011;
  localparam logic [8:0] A2   = 9'b010_011_100;
  localparam logic [8:0] A3   = 9'b011_100_101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  seq_ctrl_if #(.CNT_W(3)) bus ();

  seq_ctrl #(.CNT_W(3), .MEM_TIMEOUT(4)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Apply inputs on the falling edge, then let combinational outputs settle.
  task automatic step(input logic s, input logic [8:0] ins, input logic rdy);
    @(negedge clk);
    bus.Start       = s;
    bus.Instruction = ins;
    bus.mem_ready   = rdy;
    #1;
  endtask

  // Expected bits: {pc_init, pc_en, mem_req, Ack, timeout_err}
  task automatic outs(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {bus.pc_init, bus.pc_en, bus.mem_req, bus.Ack, bus.timeout_err};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: outputs {pi,pe,mr,ack,te} got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cnt(input string tag, input logic [2:0] exp);
    n_assert++;
    assert (bus.cycle_count === exp) else begin
      n_fail++;
      $error("FAIL %s: cycle_count got %0d expected %0d", tag, bus.cycle_count, exp);
    end
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.Instruction = A0;
    bus.mem_ready = 1'b0;

    // Reset state
    step(0, A0, 0); outs("reset_outs", 5'b00000); cnt("reset_cnt", 3'd0);
    #2 rst_n = 1'b1;

    // Basic run: Start 3 cycles, 4 ALU ops, HALT
    step(1, A0, 0); outs("a_idle", 5'b00000);
    step(1, A0, 0); outs("a_init1", 5'b10000);
    step(1, A0, 0); outs("a_init2", 5'b10000);
    step(0, A0, 0); outs("a_init3", 5'b10000); cnt("a_init_cnt", 3'd0);
    step(0, A1, 0); outs("a_alu1", 5'b01000); cnt("a_cnt0", 3'd0);
    step(0, A2, 0); outs("a_alu2", 5'b01000); cnt("a_cnt1", 3'd1);
    step(0, A3, 0); outs("a_alu3", 5'b01000);
    step(0, A0, 0); outs("a_alu4", 5'b01000);
    step(0, HALT, 0); outs("a_halt", 5'b00000); cnt("a_cnt4", 3'd4);
    step(0, A0, 0); outs("a_done", 5'b00010); cnt("a_cnt_done", 3'd5);
    $display("scenario basic run done, cycle_count=%0d", bus.cycle_count);

    // Reset in the middle of MEM_WAIT
    step(1, A0, 0); outs("r_done_start", 5'b00010);
    step(0, A0, 0); outs("r_init", 5'b10000);
    step(0, LW, 0); outs("r_run_lw", 5'b00100);
    step(0, LW, 0); outs("r_memwait", 5'b00100); cnt("r_cnt_wait", 3'd1);
    rst_n = 1'b0;
    #1; outs("r_after_reset", 5'b00000); cnt("r_cnt_reset", 3'd0);
    #1 rst_n = 1'b1;
    step(1, A0, 0); outs("r_idle", 5'b00000);
    step(0, A0, 0); outs("r_init2", 5'b10000);
    $display("scenario reset mid-wait done");

    // Zero-wait load
    step(0, LW, 1); outs("l_lw", 5'b01100);
    step(0, HALT, 1); outs("l_halt", 5'b00000);
    step(0, A0, 0); outs("l_done", 5'b00010); cnt("l_cnt", 3'd2);
    $display("scenario zero-wait load done, cycle_count=%0d", bus.cycle_count);

    // Store with three wait cycles
    step(1, A0, 0); outs("s_done_start", 5'b00010);
    step(0, A0, 0); outs("s_init", 5'b10000);
    step(0, SW, 0); outs("s_run", 5'b00100);
    step(0, SW, 0); outs("s_wait1", 5'b00100);
    step(0, SW, 0); outs("s_wait2", 5'b00100);
    step(0, SW, 1); outs("s_ready", 5'b01100);
    step(0, HALT, 0); outs("s_halt", 5'b00000);
    step(0, A0, 0); outs("s_done", 5'b00010); cnt("s_cnt", 3'd5);
    $display("scenario store wait done, cycle_count=%0d", bus.cycle_count);

    // Memory timeout after 4 wait cycles
    step(1, A0, 0); outs("t_done_start", 5'b00010);
    step(0, A0, 0); outs("t_init", 5'b10000);
    step(0, LW, 0); outs("t_run", 5'b00100);
    step(0, LW, 0); outs("t_wait1", 5'b00100);
    step(0, LW, 0); outs("t_wait2", 5'b00100);
    step(0, LW, 0); outs("t_wait3", 5'b00100);
    step(0, LW, 0); outs("t_wait4", 5'b00000);
    step(0, A0, 0); outs("t_done", 5'b00011); cnt("t_cnt", 3'd5);
    step(1, A0, 0); outs("t_done_start", 5'b00011);
    step(0, A0, 0); outs("t_init_clear", 5'b10000); cnt("t_init_cnt", 3'd0);
    $display("scenario timeout done");

    // Saturation: 12 ALU ops then HALT
    for (int i = 0; i < 12; i++) begin
      step(0, A1, 0); outs("sat_alu", 5'b01000);
    end
    step(0, HALT, 0); outs("sat_halt", 5'b00000);
    step(0, A0, 0); outs("sat_done", 5'b00010); cnt("sat_cnt", 3'd7);
    $display("scenario saturation done, cycle_count=%0d", bus.cycle_count);

    // Abort with Start during RUN
    step(1, A0, 0); outs("ab_done_start", 5'b00010);
    step(0, A0, 0); outs("ab_init", 5'b10000);
    step(0, A1, 0); outs("ab_alu1", 5'b01000);
    step(0, A2, 0); outs("ab_alu2", 5'b01000); cnt("ab_cnt1", 3'd1);
    step(1, LW, 1); outs("ab_abort", 5'b00000);
    step(0, A0, 0); outs("ab_init2", 5'b10000); cnt("ab_cnt_clr", 3'd0);
    step(0, HALT, 0); outs("ab_halt", 5'b00000);
    step(0, A0, 0); outs("ab_done", 5'b00010); cnt("ab_cnt_done", 3'd1);
    $display("scenario abort done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
